// File: rtl/logical_checker.sv
// Scoreboard for the log_and/log_or/log_not unit: checks each vector,
// counts vectors and errors over a run of NUM_VECTORS, reports a verdict.
//
// Ports:
//   clk, rst         rising-edge clock, synchronous active-high reset
//   start            begin a run (honoured in IDLE and DONE only)
//   in_valid, a, b   applied operand pair, valid this cycle
//   log_and/or/not   unit outputs for the same a/b
//   busy, done       run in progress / run finished
//   pass             verdict while done: no failing vectors
//   mismatch         one-cycle pulse per failing vector
//   err_field        {and, or, not} miscompare bits of last failure
//   vec_count        vectors accepted this run
//   err_count        failing vectors this run (saturating)
//   first_fail_idx   index of first failure, all-ones if none
module logical_checker #(
    parameter int NUM_VECTORS = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic             a,
    input  logic             b,
    input  logic             log_and,
    input  logic             log_or,
    input  logic             log_not,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             mismatch,
    output logic [2:0]       err_field,
    output logic [CNT_W-1:0] vec_count,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] first_fail_idx
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] ALL_ONES = '1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VECTORS - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    state_t state;
    state_t state_nx;

    logic             accept;
    logic             restart;
    logic             last;
    logic             fail;
    logic [2:0]       miscmp;
    logic [CNT_W-1:0] err_inc;

    assign accept  = (state == RUN) && in_valid;
    // start in RUN is ignored; in IDLE/DONE it wins over in_valid
    assign restart = (state != RUN) && start;
    assign last    = accept && (vec_count == LAST_IDX);

    assign miscmp = {log_and ^ (a & b),
                     log_or  ^ (a | b),
                     log_not ^ ~a};
    assign fail   = |miscmp;

    assign err_inc = (err_count == ALL_ONES) ? err_count
                                             : err_count + ONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last)  state_nx = DONE;
            DONE:    if (start) state_nx = RUN;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            mismatch       <= 1'b0;
            err_field      <= 3'b000;
            vec_count      <= '0;
            err_count      <= '0;
            first_fail_idx <= ALL_ONES;
        end else begin
            busy     <= (state_nx == RUN);
            done     <= (state_nx == DONE);
            mismatch <= 1'b0;
            if (restart) begin
                pass           <= 1'b0;
                err_field      <= 3'b000;
                vec_count      <= '0;
                err_count      <= '0;
                first_fail_idx <= ALL_ONES;
            end else if (accept) begin
                vec_count <= vec_count + ONE;
                if (fail) begin
                    err_count <= err_inc;
                    err_field <= miscmp;
                    mismatch  <= 1'b1;
                    if (err_count == '0) begin
                        first_fail_idx <= vec_count;
                    end
                end
                // verdict includes the final vector itself
                if (last) begin
                    pass <= !fail && (err_count == '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_logical_checker.sv
// Bench for logical_checker: two instances (default and CNT_W=2/N=3),
// checked every cycle against a spec-level model plus literal pins.
module tb_logical_checker;

    logic clk = 1'b0;
    logic rst, start, in_valid, a, b, la, lo, ln;

    logic       busy1, done1, pass1, mm1;
    logic [2:0] ef1;
    logic [7:0] vc1, ec1, ffi1;

    logic       busy2, done2, pass2, mm2;
    logic [2:0] ef2;
    logic [1:0] vc2, ec2, ffi2;

    int n_cmp = 0;
    int n_bad = 0;
    bit en = 1'b0;

    always #5 clk = ~clk;

    logical_checker #(.NUM_VECTORS(4), .CNT_W(8)) u1 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .a(a), .b(b), .log_and(la), .log_or(lo), .log_not(ln),
        .busy(busy1), .done(done1), .pass(pass1), .mismatch(mm1),
        .err_field(ef1), .vec_count(vc1), .err_count(ec1),
        .first_fail_idx(ffi1)
    );

    logical_checker #(.NUM_VECTORS(3), .CNT_W(2)) u2 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .a(a), .b(b), .log_and(la), .log_or(lo), .log_not(ln),
        .busy(busy2), .done(done2), .pass(pass2), .mismatch(mm2),
        .err_field(ef2), .vec_count(vc2), .err_count(ec2),
        .first_fail_idx(ffi2)
    );

    // phase: 0 idle, 1 running, 2 finished
    typedef struct {
        int ph;
        int vc;
        int ec;
        int ffi;
        int ef;
        int mm;
    } mdl_t;

    mdl_t m1, m2;

    function automatic mdl_t fresh(int maxv, int ph);
        mdl_t m;
        m.ph  = ph;
        m.vc  = 0;
        m.ec  = 0;
        m.ffi = maxv;
        m.ef  = 0;
        m.mm  = 0;
        return m;
    endfunction

    function automatic mdl_t step(mdl_t m, int num, int maxv);
        int e;
        if (rst) return fresh(maxv, 0);
        m.mm = 0;
        if (m.ph != 1) begin
            if (start) m = fresh(maxv, 1);
        end else if (in_valid) begin
            e = 0;
            if (la != (a && b)) e += 4;
            if (lo != (a || b)) e += 2;
            if (ln != !a)       e += 1;
            if (e != 0) begin
                if (m.ec == 0) m.ffi = m.vc;
                if (m.ec < maxv) m.ec++;
                m.ef = e;
                m.mm = 1;
            end
            m.vc++;
            if (m.vc == num) m.ph = 2;
        end
        return m;
    endfunction

    always @(posedge clk) begin
        m1 = step(m1, 4, 255);
        m2 = step(m2, 3, 3);
        en = 1'b1;
    end

    task automatic chk(string nm, int got, int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d @%0t",
                     nm, got, exp, $time);
        end
    endtask

    task automatic chkx(string nm, logic [31:0] got, int exp);
        if ($isunknown(got)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: got X expected %0d @%0t",
                     nm, exp, $time);
        end else begin
            chk(nm, int'(got), exp);
        end
    endtask

    always @(negedge clk) begin
        if (en) begin
            chkx("busy1", 32'(busy1), int'(m1.ph == 1));
            chkx("done1", 32'(done1), int'(m1.ph == 2));
            chkx("pass1", 32'(pass1), int'(m1.ph == 2 && m1.ec == 0));
            chkx("mm1",   32'(mm1),   m1.mm);
            chkx("ef1",   32'(ef1),   m1.ef);
            chkx("vc1",   32'(vc1),   m1.vc);
            chkx("ec1",   32'(ec1),   m1.ec);
            chkx("ffi1",  32'(ffi1),  m1.ffi);
            chkx("busy2", 32'(busy2), int'(m2.ph == 1));
            chkx("done2", 32'(done2), int'(m2.ph == 2));
            chkx("pass2", 32'(pass2), int'(m2.ph == 2 && m2.ec == 0));
            chkx("mm2",   32'(mm2),   m2.mm);
            chkx("ef2",   32'(ef2),   m2.ef);
            chkx("vc2",   32'(vc2),   m2.vc);
            chkx("ec2",   32'(ec2),   m2.ec);
            chkx("ffi2",  32'(ffi2),  m2.ffi);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic vec(bit va, bit vb, bit or0, bit not_a);
        in_valid = 1'b1;
        a  = va;
        b  = vb;
        la = va & vb;
        lo = or0 ? 1'b0 : (va | vb);
        ln = not_a ? va : ~va;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic good4();
        vec(0, 0, 0, 0);
        vec(0, 1, 0, 0);
        vec(1, 0, 0, 0);
        vec(1, 1, 0, 0);
    endtask

    initial begin
        m1 = fresh(255, 0);
        m2 = fresh(3, 0);
        rst = 1'b1; start = 1'b0; in_valid = 1'b0;
        a = 1'b0; b = 1'b0; la = 1'b0; lo = 1'b0; ln = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ffi", int'(ffi1), 255);
        chk("rst_busy", int'(busy1), 0);
        tick();

        // vectors in IDLE are ignored
        vec(1, 1, 0, 0);
        vec(0, 1, 1, 0);
        @(negedge clk);
        chk("idle_vc", int'(vc1), 0);
        chk("idle_ec", int'(ec1), 0);

        // correct unit, back-to-back
        pulse_start();
        good4();
        @(negedge clk);
        chk("t1_done", int'(done1), 1);
        chk("t1_pass", int'(pass1), 1);
        chk("t1_vc", int'(vc1), 4);
        chk("t1_ffi", int'(ffi1), 255);

        // log_or stuck at 0 on ab=01 and ab=11
        pulse_start();
        vec(0, 0, 0, 0);
        vec(0, 1, 1, 0);
        vec(1, 0, 0, 0);
        vec(1, 1, 1, 0);
        @(negedge clk);
        chk("t2_mm", int'(mm1), 1);
        chk("t2_ec", int'(ec1), 2);
        chk("t2_ffi", int'(ffi1), 1);
        chk("t2_ef", int'(ef1), 3'b010);
        chk("t2_pass", int'(pass1), 0);

        // in_valid in DONE, then gaps of 0..3 in RUN
        vec(1, 1, 1, 0);
        pulse_start();
        vec(0, 0, 0, 0);
        vec(0, 1, 0, 0);
        tick();
        vec(1, 0, 0, 0);
        repeat (3) tick();
        vec(1, 1, 0, 0);
        @(negedge clk);
        chk("t3_done", int'(done1), 1);
        chk("t3_vc", int'(vc1), 4);
        vec(0, 1, 1, 0);
        @(negedge clk);
        chk("t3_vc_hold", int'(vc1), 4);

        // reset mid-run
        pulse_start();
        vec(0, 1, 1, 0);
        vec(1, 1, 0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("t4_vc", int'(vc1), 0);
        chk("t4_ec", int'(ec1), 0);
        chk("t4_busy", int'(busy1), 0);
        chk("t4_ef", int'(ef1), 0);
        pulse_start();
        good4();
        @(negedge clk);
        chk("t4_pass", int'(pass1), 1);

        // start inside RUN ignored, alone and alongside a vector
        pulse_start();
        vec(0, 0, 0, 0);
        pulse_start();
        start = 1'b1;
        vec(1, 1, 0, 0);
        start = 1'b0;
        @(negedge clk);
        chk("t6_vc", int'(vc1), 2);
        chk("t6_busy", int'(busy1), 1);
        vec(0, 1, 0, 0);
        vec(1, 0, 0, 0);
        @(negedge clk);
        chk("t6_done", int'(done1), 1);
        // start with in_valid in DONE restarts, vector not counted
        start = 1'b1;
        vec(1, 0, 1, 0);
        start = 1'b0;
        @(negedge clk);
        chk("t6_rs_vc", int'(vc1), 0);
        chk("t6_rs_busy", int'(busy1), 1);
        chk("t6_rs_ec", int'(ec1), 0);

        // every vector fails on log_not; small counters must not wrap
        vec(0, 0, 0, 1);
        vec(0, 1, 0, 1);
        vec(1, 1, 0, 1);
        @(negedge clk);
        chk("t5_done2", int'(done2), 1);
        chk("t5_ec2", int'(ec2), 3);
        chk("t5_ef2", int'(ef2), 3'b001);
        chk("t5_ffi2", int'(ffi2), 0);
        chk("t5_pass2", int'(pass2), 0);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/logical_checker.md
# logical_checker

Self-checking scoreboard stage that sits directly downstream of the two-input logical-operator unit (`log_and`, `log_or`, `log_not`). Each cycle it samples one applied input pair `a`/`b` together with the unit's three outputs. It computes the expected results (`a && b`, `a || b`, `!a`) and flags mismatches. It also counts vectors and errors over a run of `NUM_VECTORS`, then reports a pass/fail verdict.

## Interface
Parameters:
- `NUM_VECTORS`, default 4: vectors per run; legal range 1 to 2^`CNT_W`-1.
- `CNT_W`, default 8: width of all counters and indices.

Ports:
- `clk`, input, 1: single clock; all logic is rising-edge.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: begins a run; sampled in IDLE and DONE only.
- `in_valid`, input, 1: `a`/`b`/`log_*` hold a valid vector this cycle.
- `a`, `b`, input, 1: operands applied to the upstream unit.
- `log_and`, `log_or`, `log_not`, input, 1: unit outputs for the same `a`/`b`, valid in the same cycle.
- `busy`, output, 1: high in RUN.
- `done`, output, 1: high in DONE.
- `pass`, output, 1: valid while `done`; 1 iff `err_count`==0.
- `mismatch`, output, 1: one-cycle pulse, registered, for a failing vector.
- `err_field`, output, 3: {and, or, not} miscompare bits of the last failing vector, held.
- `vec_count`, output, `CNT_W`: vectors accepted in the current run.
- `err_count`, output, `CNT_W`: failing vectors in the current run; saturates at all-ones.
- `first_fail_idx`, output, `CNT_W`: `vec_count` value (0-based) of the first failure; all-ones if none.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on `start`.
  - RUN -> DONE on acceptance of vector number `NUM_VECTORS`.
  - DONE -> RUN on `start`.
  - No other transitions.
- Entering RUN clears `vec_count`, `err_count` and `err_field`, and sets `first_fail_idx` to all-ones.
- Acceptance: `in_valid`=1 while in RUN. `in_valid` in IDLE or DONE is ignored, with no counter change.
- Expected values: `exp_and = a & b`, `exp_or = a | b`, `exp_not = ~a`.
- Miscompare vector: `{log_and^exp_and, log_or^exp_or, log_not^exp_not}`. The vector fails if any bit is set.
- On an accepted vector:
  - `vec_count` increments.
  - On failure: `err_count` increments (saturating), `err_field` is loaded, and `mismatch` pulses.
  - On the first failure of the run: `first_fail_idx` loads the pre-increment `vec_count`.
- `start` in RUN is ignored. A `start` that coincides with an `in_valid` in DONE restarts the run; that vector is not accepted.
- Reset values:
  - State IDLE.
  - `busy`=0, `done`=0, `pass`=0, `mismatch`=0.
  - `err_field`=0, `vec_count`=0, `err_count`=0.
  - `first_fail_idx`=all-ones.
- Reset has priority over all inputs. Reset mid-run discards the run with no verdict.

## Timing
- All outputs are registered.
- Latency is 1 cycle: a vector accepted at edge N updates `vec_count`, `err_count`, `err_field` and `mismatch` after edge N.
- `start` at edge N: `busy`=1 from N; counters are cleared at N. The first vector can be accepted at edge N+1.
- Last vector accepted at edge N: `busy` 1->0 and `done` 0->1 after N. In the same cycle, `err_count` and `pass` already include that vector.
- `done` and `pass` hold until the next `start` or `rst`. `pass`=0 whenever `done`=0.
- `mismatch` is high for exactly one cycle per failing vector. Back-to-back failures give back-to-back high cycles.
- Gaps (`in_valid`=0) in RUN are allowed for any length and do not advance the counters.

## Test plan
- Correct unit model, `NUM_VECTORS`=4, vectors ab = 00, 01, 10, 11 back-to-back:
  - `done` 1 cycle after the 4th vector.
  - `pass`=1, `err_count`=0, `vec_count`=4, `first_fail_idx`=8'hFF, no `mismatch` pulse.
- Same vectors with `log_or` forced 0 on ab=01 and ab=11:
  - `mismatch` pulses after vectors 1 and 3.
  - `err_count`=2, `first_fail_idx`=1, `err_field`=3'b010, `pass`=0.
- `in_valid` gaps of 0-3 cycles, plus `in_valid` in IDLE before `start` and in DONE after it:
  - `vec_count` counts only the 4 vectors accepted in RUN.
  - `done` follows the last accepted vector by 1 cycle.
- `rst` asserted after 2 vectors: all outputs return to their reset values. A new `start` plus 4 good vectors gives `pass`=1.
- `CNT_W`=2, `NUM_VECTORS`=3, all vectors failing (`log_not`=a): `err_count`=3, with no wrap to 0; `err_field`=3'b001.
- `start` pulsed in RUN is ignored. `start` in DONE coinciding with `in_valid`: counters clear, `vec_count`=0, `busy`=1.
